// File: rtl/mc_bus_pkg.sv
// Shared bus types for the per-core requesters: FSM state, widths
// and the captured command bundle.
package mc_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_ID_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_WAIT,
    ST_RESP
  } bus_req_state_e;

  // Widest command the agent can hold; narrower agents zero-extend.
  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_ID_W-1:0]   id;
  } bus_cmd_t;

endpackage

// File: rtl/bus_req_agent_if.sv
// Core-side and bus-side signals of one requester.
// master: agent view; slave: core/arbiter/bus view.
interface bus_req_agent_if
  import mc_bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int ID_W   = BUS_ID_W
);

  logic              core_valid;
  logic              core_ready;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_rsp_valid;
  logic [DATA_W-1:0] core_rsp_rdata;
  logic              core_rsp_err;
  logic              req_arb;
  logic              gnt_arb;
  logic              bus_cmd_valid;
  logic              bus_cmd_we;
  logic [ADDR_W-1:0] bus_cmd_addr;
  logic [DATA_W-1:0] bus_cmd_wdata;
  logic [ID_W-1:0]   bus_cmd_id;
  logic              bus_rsp_valid;
  logic [ID_W-1:0]   bus_rsp_id;
  logic [DATA_W-1:0] bus_rsp_rdata;

  modport master (
    input  core_valid, core_we, core_addr, core_wdata,
    input  gnt_arb,
    input  bus_rsp_valid, bus_rsp_id, bus_rsp_rdata,
    output core_ready, core_rsp_valid,
    output core_rsp_rdata, core_rsp_err,
    output req_arb,
    output bus_cmd_valid, bus_cmd_we, bus_cmd_addr,
    output bus_cmd_wdata, bus_cmd_id
  );

  modport slave (
    output core_valid, core_we, core_addr, core_wdata,
    output gnt_arb,
    output bus_rsp_valid, bus_rsp_id, bus_rsp_rdata,
    input  core_ready, core_rsp_valid,
    input  core_rsp_rdata, core_rsp_err,
    input  req_arb,
    input  bus_cmd_valid, bus_cmd_we, bus_cmd_addr,
    input  bus_cmd_wdata, bus_cmd_id
  );

endinterface

// File: rtl/bus_req_timer.sv
// Clearable saturating counter for the response wait (built only
// with BUS_REQ_TIMEOUT_EN). Ports: clk, rst (async low), clr, en, cnt.
`ifdef BUS_REQ_TIMEOUT_EN
module bus_req_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/bus_req_agent.sv
// Per-core bus requester: one command in flight, arbitration, tagged
// response return. Ports: clk, rst (async low), bus (interface,
// master). Optional response timeout: macro BUS_REQ_TIMEOUT_EN.
module bus_req_agent
  import mc_bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int ID_W    = BUS_ID_W,
  parameter int CORE_ID = 0,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  bus_req_agent_if.master bus
);

  bus_req_state_e    state_q;
  bus_cmd_t          cmd_q;
  logic [DATA_W-1:0] rdata_q;
  logic              in_arb;
  logic              in_wait;
  logic              rsp_hit;
  logic              tmo;

  assign in_arb  = (state_q == ST_ARB);
  assign in_wait = (state_q == ST_WAIT);
  assign rsp_hit = in_wait && bus.bus_rsp_valid &&
                   (bus.bus_rsp_id == ID_W'(CORE_ID));

`ifdef BUS_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  bus_req_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (in_arb && bus.gnt_arb),
    .en  (in_wait),
    .cnt (cnt)
  );

  // Last WAIT cycle is the TIMEOUT-th one.
  assign tmo = in_wait && (cnt == CNT_W'(TIMEOUT - 1));
  assign bus.core_rsp_err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout   = (TIMEOUT != 0);
  assign tmo              = 1'b0;
  assign bus.core_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
`ifdef BUS_REQ_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.core_valid) begin
            cmd_q.we    <= bus.core_we;
            cmd_q.addr  <= BUS_ADDR_W'(bus.core_addr);
            cmd_q.wdata <= BUS_DATA_W'(bus.core_wdata);
            cmd_q.id    <= BUS_ID_W'(CORE_ID);
            state_q     <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (bus.gnt_arb) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rsp_hit) begin
            rdata_q <= cmd_q.we ? '0 : bus.bus_rsp_rdata;
`ifdef BUS_REQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            state_q <= ST_RESP;
          end else if (tmo) begin
            rdata_q <= '0;
`ifdef BUS_REQ_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          rdata_q <= '0;
`ifdef BUS_REQ_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // rst gates ready so the core sees 0 while held in reset.
  assign bus.core_ready     = rst && (state_q == ST_IDLE);
  assign bus.core_rsp_valid = (state_q == ST_RESP);
  assign bus.core_rsp_rdata = rdata_q;

  assign bus.req_arb       = in_arb;
  assign bus.bus_cmd_valid = in_arb && bus.gnt_arb;
  assign bus.bus_cmd_we    = in_arb && cmd_q.we;
  assign bus.bus_cmd_addr  = in_arb ? ADDR_W'(cmd_q.addr) : '0;
  assign bus.bus_cmd_wdata = in_arb ? DATA_W'(cmd_q.wdata) : '0;
  assign bus.bus_cmd_id    = in_arb ? ID_W'(cmd_q.id) : '0;

endmodule

// File: tb/tb_bus_req_agent.sv
// Randomised + directed bench for bus_req_agent with a
// transaction-level model; timeout cases need BUS_REQ_TIMEOUT_EN.
module tb_bus_req_agent;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 2;
  localparam int CID = 1;
  localparam int TO  = 8;
`ifdef BUS_REQ_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk;
  logic rst;

  bus_req_agent_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bif ();

  bus_req_agent #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .ID_W    (IW),
    .CORE_ID (CID),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int cycle;

  // model: one command from accept to delivered response
  bit          m_busy;
  bit          m_iss;
  bit          m_dlv;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  bit          m_err;
  int          m_wcnt;

  // observations for the directed literal checks
  int          n_cmd;
  int          n_rsp;
  int          n_req_wait;
  int          acc_cyc;
  int          rsp_cyc;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [31:0] last_cmd_addr;
  logic [1:0]  last_cmd_id;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got %h want %h",
               nm, cycle, act, exp);
    end
  endfunction

  task automatic mon_clear();
    n_cmd = 0;
    n_rsp = 0;
    n_req_wait = 0;
    acc_cyc = -1;
    rsp_cyc = -1;
    last_rdata = '0;
    last_err = 1'b0;
    last_cmd_addr = '0;
    last_cmd_id = '0;
  endtask

  task automatic check_cycle();
    bit e_idle;
    bit e_req;
    bit e_cv;
    cycle++;
    if (!rst) begin
      m_busy = 0;
      m_iss  = 0;
      m_dlv  = 0;
      m_wcnt = 0;
    end
    e_idle = !m_busy && !m_dlv;
    e_req  = m_busy && !m_iss;
    e_cv   = e_req && bif.gnt_arb;
    chk("ready", 64'(bif.core_ready), 64'(rst && e_idle));
    chk("req_arb", 64'(bif.req_arb), 64'(e_req));
    chk("cmd_valid", 64'(bif.bus_cmd_valid), 64'(e_cv));
    chk("rsp_valid", 64'(bif.core_rsp_valid), 64'(m_dlv));
    chk("rsp_err", 64'(bif.core_rsp_err), 64'(m_dlv && m_err));
    if (m_dlv || e_idle)
      chk("rsp_rdata", 64'(bif.core_rsp_rdata),
          64'(m_dlv ? m_rdata : 32'h0));
    if (e_cv) begin
      chk("cmd_we", 64'(bif.bus_cmd_we), 64'(m_we));
      chk("cmd_addr", 64'(bif.bus_cmd_addr), 64'(m_addr));
      chk("cmd_wdata", 64'(bif.bus_cmd_wdata), 64'(m_wdata));
      chk("cmd_id", 64'(bif.bus_cmd_id), 64'(CID));
    end else if (e_idle) begin
      chk("cmd_fields_zero",
          64'({bif.bus_cmd_we, bif.bus_cmd_addr,
               bif.bus_cmd_wdata, bif.bus_cmd_id}), 64'h0);
    end
    if (bif.bus_cmd_valid) begin
      n_cmd++;
      last_cmd_addr = bif.bus_cmd_addr;
      last_cmd_id = bif.bus_cmd_id;
    end
    if (bif.req_arb && !bif.bus_cmd_valid) n_req_wait++;
    if (bif.core_valid && bif.core_ready) acc_cyc = cycle;
    if (bif.core_rsp_valid) begin
      n_rsp++;
      rsp_cyc = cycle;
      last_rdata = bif.core_rsp_rdata;
      last_err = bif.core_rsp_err;
    end
    if (rst) begin
      if (m_dlv) begin
        m_dlv = 0;
      end else if (!m_busy) begin
        if (bif.core_valid) begin
          m_busy  = 1;
          m_iss   = 0;
          m_we    = bif.core_we;
          m_addr  = bif.core_addr;
          m_wdata = bif.core_wdata;
        end
      end else if (!m_iss) begin
        if (bif.gnt_arb) begin
          m_iss  = 1;
          m_wcnt = 0;
        end
      end else if (bif.bus_rsp_valid && bif.bus_rsp_id == CID) begin
        m_dlv   = 1;
        m_busy  = 0;
        m_rdata = m_we ? 32'h0 : bif.bus_rsp_rdata;
        m_err   = 0;
      end else if (TMO) begin
        m_wcnt++;
        if (m_wcnt == TO) begin
          m_dlv   = 1;
          m_busy  = 0;
          m_rdata = 32'h0;
          m_err   = 1;
        end
      end
    end
  endtask

  // inputs already driven; check, then move to next drive window
  task automatic cyc();
    #2;
    check_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    bif.core_valid    = 1'b0;
    bif.core_we       = 1'b0;
    bif.core_addr     = '0;
    bif.core_wdata    = '0;
    bif.gnt_arb       = 1'b0;
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rsp_id    = '0;
    bif.bus_rsp_rdata = '0;
  endtask

  task automatic cmd(bit we, logic [31:0] a, logic [31:0] d);
    bif.core_valid = 1'b1;
    bif.core_we    = we;
    bif.core_addr  = a;
    bif.core_wdata = d;
  endtask

  task automatic rsp(logic [1:0] id, logic [31:0] d);
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rsp_id    = id;
    bif.bus_rsp_rdata = d;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cycle = 0;
    m_busy = 0; m_iss = 0; m_dlv = 0; m_we = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_wcnt = 0;
    mon_clear();
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    #1;
    chk("reset_ready_low", 64'(bif.core_ready), 64'h0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // store, immediate grant, response one cycle later
    mon_clear();
    cmd(1'b1, 32'h100, 32'hDEAD);
    bif.gnt_arb = 1'b1;
    cyc();
    bif.core_valid = 1'b0;
    cyc();
    bif.gnt_arb = 1'b0;
    rsp(2'(CID), 32'h7777);
    cyc();
    idle_in();
    cyc();
    cyc();
    chk("t1_cmds", 64'(n_cmd), 64'd1);
    chk("t1_cmd_id", 64'(last_cmd_id), 64'd1);
    chk("t1_cmd_addr", 64'(last_cmd_addr), 64'h100);
    chk("t1_rsps", 64'(n_rsp), 64'd1);
    chk("t1_rdata", 64'(last_rdata), 64'h0);
    chk("t1_err", 64'(last_err), 64'h0);
    chk("t1_turnaround", 64'(rsp_cyc - acc_cyc), 64'd3);

    // load, grant withheld 5 cycles
    mon_clear();
    cmd(1'b0, 32'h200, 32'h0);
    cyc();
    bif.core_valid = 1'b0;
    repeat (5) cyc();
    bif.gnt_arb = 1'b1;
    cyc();
    bif.gnt_arb = 1'b0;
    cyc();
    rsp(2'(CID), 32'h1234);
    cyc();
    idle_in();
    cyc();
    cyc();
    chk("t2_req_wait", 64'(n_req_wait), 64'd5);
    chk("t2_cmds", 64'(n_cmd), 64'd1);
    chk("t2_rdata", 64'(last_rdata), 64'h1234);

    // foreign ids ignored during WAIT
    mon_clear();
    cmd(1'b0, 32'h300, 32'h0);
    cyc();
    bif.core_valid = 1'b0;
    bif.gnt_arb = 1'b1;
    cyc();
    bif.gnt_arb = 1'b0;
    rsp(2'd2, 32'hBAD);
    cyc();
    rsp(2'd0, 32'hBAD0);
    cyc();
    idle_in();
    cyc();
    rsp(2'(CID), 32'h5678);
    cyc();
    idle_in();
    repeat (3) cyc();
    chk("t3_rsps", 64'(n_rsp), 64'd1);
    chk("t3_rdata", 64'(last_rdata), 64'h5678);

    // reset in ARB, then in WAIT
    mon_clear();
    cmd(1'b0, 32'h500, 32'h0);
    cyc();
    bif.core_valid = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    chk("t4_req_async", 64'(bif.req_arb), 64'h0);
    cyc();
    rst = 1'b1;
    cyc();
    cmd(1'b1, 32'h504, 32'h99);
    cyc();
    bif.core_valid = 1'b0;
    bif.gnt_arb = 1'b1;
    cyc();
    bif.gnt_arb = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    rsp(2'(CID), 32'h42);
    cyc();
    idle_in();
    repeat (2) cyc();
    chk("t4_rsps", 64'(n_rsp), 64'd0);
    chk("t4_cmds", 64'(n_cmd), 64'd1);

`ifdef BUS_REQ_TIMEOUT_EN
    // timeout, then a late matching response
    mon_clear();
    cmd(1'b0, 32'h600, 32'h0);
    bif.gnt_arb = 1'b1;
    cyc();
    bif.core_valid = 1'b0;
    cyc();
    bif.gnt_arb = 1'b0;
    repeat (9) cyc();
    rsp(2'(CID), 32'hCAFE);
    cyc();
    idle_in();
    repeat (3) cyc();
    chk("t5_rsps", 64'(n_rsp), 64'd1);
    chk("t5_err", 64'(last_err), 64'h1);
    chk("t5_rdata", 64'(last_rdata), 64'h0);
    chk("t5_latency", 64'(rsp_cyc - acc_cyc), 64'd10);
`endif

    // back-to-back commands
    mon_clear();
    for (int i = 0; i < 14; i++) begin
      if (i < 10) cmd(1'b0, 32'h400 + 32'(i), 32'h0);
      else bif.core_valid = 1'b0;
      bif.gnt_arb = 1'b1;
      rsp(2'(CID), 32'hA5A5_0000 + 32'(i));
      cyc();
    end
    idle_in();
    cyc();
    chk("t6_cmds", 64'(n_cmd), 64'd3);
    chk("t6_rsps", 64'(n_rsp), 64'd3);
    chk("t6_last_addr", 64'(last_cmd_addr), 64'h408);

    // random traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      bif.core_valid    = ($urandom_range(0, 2) != 0);
      bif.core_we       = 1'($urandom);
      bif.core_addr     = $urandom;
      bif.core_wdata    = $urandom;
      bif.gnt_arb       = ($urandom_range(0, 2) == 0);
      bif.bus_rsp_valid = ($urandom_range(0, 3) == 0);
      bif.bus_rsp_id    = 2'($urandom);
      bif.bus_rsp_rdata = $urandom;
      rst = (!rst) ? 1'b1 : ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst = 1'b1;
    idle_in();
    repeat (20) cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_req_agent.md
# bus_req_agent

Per-core requester for the shared bus round-robin arbiter: accepts one load/store command at a time from its core, raises that core's arbiter request, issues the command on the shared bus in the cycle it is granted, then waits for the tagged response and returns it to the core. One instance per core (three in the system), each driving one `req_arb` bit and observing the matching `gnt_arb` bit.

## Interface
Parameters:
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width
- `ID_W`, 2: bus transaction ID width
- `CORE_ID`, 0: this agent's ID, driven on commands and matched on responses
- `TIMEOUT`, 255: response-wait limit in cycles (only with the macro under Configuration)

Ports:
- `clk`  in  1: sole clock, rising edge
- `rst`  in  1: reset, asynchronous assert, active-low (0 = reset)
- `core_valid`  in  1: core command valid
- `core_ready`  out  1: agent can accept a command
- `core_we`  in  1: 1 = store, 0 = load
- `core_addr`  in  ADDR_W: command address
- `core_wdata`  in  DATA_W: store data
- `core_rsp_valid`  out  1: one-cycle response pulse
- `core_rsp_rdata`  out  DATA_W: load data (0 for stores and errors)
- `core_rsp_err`  out  1: response is a timeout error
- `req_arb`  out  1: request to arbiter
- `gnt_arb`  in  1: grant from arbiter (combinational, same cycle)
- `bus_cmd_valid`  out  1: command on bus this cycle
- `bus_cmd_we`, `bus_cmd_addr`, `bus_cmd_wdata`, `bus_cmd_id`  out  1/ADDR_W/DATA_W/ID_W: command fields
- `bus_rsp_valid`  in  1: response on bus
- `bus_rsp_id`  in  ID_W: response owner
- `bus_rsp_rdata`  in  DATA_W: response data

## Operation
- States: IDLE, ARB, WAIT, RESP.
- IDLE: `core_ready`=1. On `core_valid`: capture we/addr/wdata, go to ARB.
- ARB: `req_arb`=1. `bus_cmd_valid` = `gnt_arb` (combinational); command fields come from the capture registers, `bus_cmd_id`=CORE_ID. On `gnt_arb`=1, go to WAIT. Grant may move between cycles; the command is single-beat, so no grant holding is required.
- WAIT: `req_arb`=0. On `bus_rsp_valid` && `bus_rsp_id`==CORE_ID: register rdata (0 if store), err=0, go to RESP.
- RESP: `core_rsp_valid`=1 for exactly one cycle, then IDLE. The core must always accept responses (no backpressure).
- Responses carrying CORE_ID outside WAIT are dropped silently.
- Outputs during reset and in IDLE: `req_arb`=0, `bus_cmd_valid`=0, `core_rsp_valid`=0, `core_rsp_err`=0, `core_rsp_rdata`=0, `bus_cmd_*` fields 0; `core_ready`=1 only once reset is released.

## Timing
- Accept at edge N; `req_arb` high from cycle N+1.
- If granted in cycle N+1, the command appears in that same cycle.
- A response at earliest cycle N+2 produces `core_rsp_valid` in cycle N+3.
- Minimum command-to-response turnaround is 3 cycles. Throughput is one outstanding command.
- Reset mid-operation: state goes to IDLE and `req_arb` and `bus_cmd_valid` drop immediately (asynchronous). The captured command is discarded.
- A response arriving in the same cycle as the grant is not possible from a legal bus and is ignored.

## Configuration
- `BUS_REQ_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no matching response, go to RESP with `core_rsp_err`=1 and rdata=0.
  - A late response is then dropped.
- `BUS_REQ_TIMEOUT_EN` undefined:
  - WAIT lasts indefinitely.
  - No counter is built; `core_rsp_err` is tied 0.

## Structure
- Shared package `mc_bus_pkg`:
  - state enum `bus_req_state_e`
  - `ID_W` default
  - command struct `bus_cmd_t` (we, addr, wdata, id)
- Optional sub-module `bus_req_timer`: the clearable saturating WAIT counter, instantiated only under the macro.

## Test plan
- Store addr 0x100, data 0xDEAD; `gnt_arb` high immediately; response id CORE_ID one cycle later -> one `bus_cmd_valid` pulse with id CORE_ID, `core_rsp_valid` with rdata 0, err 0; turnaround 3 cycles.
- Load with `gnt_arb` withheld 5 cycles -> `req_arb` held 5 cycles, no command; command on the grant cycle; rdata 0x1234 returned.
- Response with id≠CORE_ID during WAIT -> ignored; later matching response is delivered; exactly one `core_rsp_valid`.
- `rst` pulled low while in ARB and again in WAIT -> `req_arb`=0 asynchronously, IDLE after release, no response pulse.
- With `BUS_REQ_TIMEOUT_EN`, TIMEOUT=8, no response -> err=1 after 8 WAIT cycles; a matching response at cycle 10 is dropped.
- Back-to-back commands -> `core_ready` low from accept until the RESP cycle ends; second command issued correctly.
